contador_jk_updown: RTL
=======================

# contador_jk_updown

Synchronous 4-bit up/down modulo-N counter that produces the J/K excitation pattern for a bank of four JK flip-flop stages. It sits directly upstream of the JK flip-flop stage. Its J and K outputs are what a bank of JK flip-flops must receive to reproduce the same count sequence. Q holds the counter's own registered state, so the flip-flop bank can be cross-checked against it.

## Interface

- MODULO, default 10: count modulus, legal range 2..16; the count runs 0..MODULO-1.
- clk  in  1  clock; all state changes on the rising edge.
- CLR  in  1  asynchronous, active-high reset; clears Q and ERR immediately, independent of clk.
- EN  in  1  count enable.
- UP  in  1  direction; 1 = increment, 0 = decrement.
- LOAD  in  1  synchronous parallel load; priority over EN.
- D  in  4  load value.
- Q  out  4  registered count.
- J  out  4  combinational J excitation per bit for the next edge.
- K  out  4  combinational K excitation per bit for the next edge.
- TC  out  1  combinational terminal count.
- ERR  out  1  registered sticky flag: an out-of-range load occurred.

## Operation

- Next-state N is computed combinationally. Priority, highest first:
  - LOAD=1: N = D if D < MODULO, else N = 0.
  - EN=1, UP=1: N = Q+1; at Q = MODULO-1, N = 0.
  - EN=1, UP=0: N = Q-1; at Q = 0, N = MODULO-1.
  - EN=0 and LOAD=0: N = Q (hold).
- Excitation outputs, per bit i, minimal form with no toggle code used for holds:
  - J[i] = ~Q[i] & N[i] (0→1 transition).
  - K[i] = Q[i] & ~N[i] (1→0 transition).
  - J[i] and K[i] are never both 1.
  - Bits that hold produce J=K=0.
- Q <= N on every rising clk edge while CLR=0.
- Width rules:
  - All arithmetic is 4-bit.
  - Wrap is decided by comparing against MODULO-1 and 0, never by 4-bit overflow. This keeps Q < MODULO at all times after reset.
- TC = EN & ~LOAD & ((UP & Q==MODULO-1) | (~UP & Q==0)). TC is used for cascading counters.
- ERR:
  - Set on the edge where LOAD=1 and D >= MODULO.
  - Stays set until CLR.
  - A valid load does not clear it.

## Timing

- Reset values while CLR=1: Q=0, ERR=0. J, K and TC follow combinationally from Q=0 and the current inputs.
- Reset response:
  - CLR asserts asynchronously; Q reaches 0 without waiting for a clock edge.
  - While CLR is high, clock edges are ignored.
  - Release is sampled at the first rising edge after CLR falls.
- Mid-operation CLR: a CLR pulse between edges zeroes Q immediately. A load or count pending for the next edge is discarded.
- Latency:
  - Count/load: one cycle from input to Q.
  - J, K, TC: zero-cycle combinational from Q, EN, UP, LOAD, D. They are valid before the edge they target.
- Simultaneous LOAD and EN: the load wins and TC is forced to 0.
- UP changing at the wrap point: the direction sampled at the edge decides. With Q = MODULO-1 and UP=0, the next state is MODULO-2; no wrap.
- EN=0 holds Q, drives J=K=0 and TC=0.

## Test plan

- Reset: CLR=1 mid-cycle with Q=7 → Q=0 before the next edge, ERR=0. Release CLR with EN=1, UP=1 → Q=1 after one edge.
- Up count, MODULO=10: EN=1, UP=1 for 12 edges from 0 → Q goes 0..9, 0, 1.
  - TC=1 only while Q=9.
  - At Q=7→8: J=4'b1000, K=4'b0111.
  - At Q=9→0: J=0, K=4'b1001.
- Down count: EN=1, UP=0 from Q=0 → Q=9, 8, 7.
  - TC=1 only at Q=0.
  - At Q=0→9: J=4'b1001, K=0.
- Load:
  - LOAD=1, EN=1, D=5 → Q=5 next edge, TC=0 during the load cycle.
  - LOAD=1, D=12 → Q=0, ERR=1.
  - Subsequent valid load D=3 → Q=3, ERR still 1.
- Hold and direction switch:
  - EN=0 at Q=4 for 3 edges → Q=4, J=K=0, TC=0.
  - Then UP toggles every edge with EN=1 → Q goes 5, 4, 5.
- Excitation consistency: 200 random cycles of EN, UP, LOAD, D feed J/K into a JK flip-flop model. The model state must equal Q every cycle, and J&K must be 0 on every bit.

Source files
------------

// File: rtl/contador_jk_updown.sv
// ---------------------------------------------------------------------------
// contador_jk_updown
//
// 4-bit synchronous up/down modulo-MODULO counter. Alongside its own
// registered count it drives the J/K excitation a bank of four JK
// flip-flops needs to follow the same sequence on the next edge.
//
// Parameters
//   MODULO  count modulus, 2..16; the count runs 0..MODULO-1
//
// Ports
//   clk   in   rising-edge clock
//   CLR   in   asynchronous active-high clear of Q and ERR
//   EN    in   count enable
//   UP    in   direction, 1 = increment, 0 = decrement
//   LOAD  in   synchronous parallel load, overrides EN
//   D     in   [3:0] load value
//   Q     out  [3:0] registered count
//   J     out  [3:0] combinational J excitation for the next edge
//   K     out  [3:0] combinational K excitation for the next edge
//   TC    out  combinational terminal count for cascading
//   ERR   out  registered sticky out-of-range-load flag
// ---------------------------------------------------------------------------
module contador_jk_updown #(
    parameter int MODULO = 10
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       EN,
    input  logic       UP,
    input  logic       LOAD,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic [3:0] J,
    output logic [3:0] K,
    output logic       TC,
    output logic       ERR
);

    localparam logic [3:0] MAXV    = 4'(MODULO - 1);
    localparam logic [4:0] MOD_W5  = 5'(MODULO);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       err_q;
    logic       err_d;
    logic       d_valid;
    logic       at_max;
    logic       at_zero;

    // D is compared in 5 bits so MODULO=16 accepts every 4-bit value.
    assign d_valid = ({1'b0, D} < MOD_W5);
    assign at_max  = (q_q == MAXV);
    assign at_zero = (q_q == 4'd0);

    // Wrap is decided by explicit compares, never by 4-bit overflow, so the
    // count can never leave 0..MODULO-1.
    always_comb begin
        q_d = q_q;
        if (LOAD) begin
            q_d = d_valid ? D : 4'd0;
        end else if (EN) begin
            if (UP) begin
                q_d = at_max ? 4'd0 : (q_q + 4'd1);
            end else begin
                q_d = at_zero ? MAXV : (q_q - 4'd1);
            end
        end
    end

    assign err_d = err_q | (LOAD & ~d_valid);

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            q_q   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    // Minimal excitation: only bits that actually change get J or K, so
    // holding bits see J=K=0 and J&K is structurally zero.
    assign J   = ~q_q & q_d;
    assign K   =  q_q & ~q_d;
    assign TC  = EN & ~LOAD & ((UP & at_max) | (~UP & at_zero));
    assign Q   = q_q;
    assign ERR = err_q;

endmodule
